// File: rtl/fp_align_seq.sv
// Sequencer for the one-bit-per-cycle mantissa aligner: accepts an operand pair, drives load/en, captures aligned mantissas.
// Latency: 2 + N cycles from accept to out_valid, where N (>=1) is the RUN cycles until norm_OE or the MAX_CYC budget.
// Backpressure: in_ready only in IDLE; out_valid holds in DONE until out_ready, with no IDLE bypass.
//
// Ports: clk/rst (sync, active-low), flush (sync abort to IDLE);
//   in_*   operand pair in over valid/ready;
//   norm_* aligner control (en/load), held operands, aligner results and done flag;
//   out_*  aligned mantissas and timeout flag out over valid/ready.
// Optional: define ALIGN_PERF_EN to add last_cycles (RUN count of the last op) and op_count (completed ops).
module fp_align_seq #(
    parameter int MW      = 53,
    parameter int EW      = 11,
    parameter int MAX_CYC = 2100,
    parameter int CW      = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] in_A,
    input  logic [MW-1:0] in_B,
    input  logic [EW-1:0] in_eA,
    input  logic [EW-1:0] in_eB,
    output logic          norm_en,
    output logic          norm_load,
    output logic [MW-1:0] norm_A,
    output logic [MW-1:0] norm_B,
    output logic [EW-1:0] norm_eA,
    output logic [EW-1:0] norm_eB,
    input  logic [MW-1:0] norm_Am,
    input  logic [MW-1:0] norm_Bm,
    input  logic          norm_OE,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_Am,
    output logic [MW-1:0] out_Bm,
`ifdef ALIGN_PERF_EN
    output logic [CW-1:0] last_cycles,
    output logic [31:0]   op_count,
`endif
    output logic          out_timeout
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [EW-1:0] op_ea_q, op_ea_d, op_eb_q, op_eb_d;
    logic [MW-1:0] res_a_q, res_a_d, res_b_q, res_b_d;
    logic          tmo_q, tmo_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_ea_d   = op_ea_q;
        op_eb_d   = op_eb_q;
        res_a_d   = res_a_q;
        res_b_d   = res_b_q;
        tmo_d     = tmo_q;
        in_ready  = 1'b0;
        norm_en   = 1'b0;
        norm_load = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_a_d  = in_A;
                    op_b_d  = in_B;
                    op_ea_d = in_eA;
                    op_eb_d = in_eB;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                norm_en   = 1'b1;
                norm_load = 1'b1;
                state_d   = SETTLE;
            end
            SETTLE: begin
                // norm_OE still reflects the previous operation here, so it is not looked at.
                norm_en = 1'b1;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                norm_en = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                // A real completion wins over a budget expiry landing on the same cycle.
                if (norm_OE) begin
                    res_a_d = norm_Am;
                    res_b_d = norm_Bm;
                    tmo_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CW'(MAX_CYC - 1)) begin
                    res_a_d = norm_Am;
                    res_b_d = norm_Bm;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort: operands and previously captured results are kept, nothing new is latched.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            op_a_d  = op_a_q;
            op_b_d  = op_b_q;
            op_ea_d = op_ea_q;
            op_eb_d = op_eb_q;
            res_a_d = res_a_q;
            res_b_d = res_b_q;
            tmo_d   = tmo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            op_ea_q <= '0;
            op_eb_q <= '0;
            res_a_q <= '0;
            res_b_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            op_ea_q <= op_ea_d;
            op_eb_q <= op_eb_d;
            res_a_q <= res_a_d;
            res_b_q <= res_b_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef ALIGN_PERF_EN
    logic [CW-1:0] last_cyc_q;
    logic [31:0]   op_cnt_q;
    logic          done_entry;

    // state_d already has flush folded in, so an aborted RUN never counts.
    assign done_entry = (state_q == RUN) && (state_d == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_cyc_q <= '0;
            op_cnt_q   <= '0;
        end else if (done_entry) begin
            last_cyc_q <= cnt_d;
            op_cnt_q   <= op_cnt_q + 32'd1;
        end
    end

    assign last_cycles = last_cyc_q;
    assign op_count    = op_cnt_q;
`endif

    assign norm_A      = op_a_q;
    assign norm_B      = op_b_q;
    assign norm_eA     = op_ea_q;
    assign norm_eB     = op_eb_q;
    assign out_Am      = res_a_q;
    assign out_Bm      = res_b_q;
    assign out_timeout = tmo_q;

endmodule

// File: tb/tb_fp_align_seq.sv
module tb_fp_align_seq;

    localparam int MW = 53;
    localparam int EW = 11;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready;
    logic [MW-1:0] in_A, in_B;
    logic [EW-1:0] in_eA, in_eB;
    logic          norm_en, norm_load;
    logic [MW-1:0] norm_A, norm_B, norm_Am, norm_Bm;
    logic [EW-1:0] norm_eA, norm_eB;
    logic          norm_OE;
    logic          out_valid, out_ready, out_timeout;
    logic [MW-1:0] out_Am, out_Bm;
`ifdef ALIGN_PERF_EN
    logic [CW-1:0] last_cycles;
    logic [31:0]   op_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_align_seq #(.MW(MW), .EW(EW), .MAX_CYC(16), .CW(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_eA(in_eA), .in_eB(in_eB),
        .norm_en(norm_en), .norm_load(norm_load),
        .norm_A(norm_A), .norm_B(norm_B), .norm_eA(norm_eA), .norm_eB(norm_eB),
        .norm_Am(norm_Am), .norm_Bm(norm_Bm), .norm_OE(norm_OE),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_Am(out_Am), .out_Bm(out_Bm),
`ifdef ALIGN_PERF_EN
        .last_cycles(last_cycles), .op_count(op_count),
`endif
        .out_timeout(out_timeout)
    );

    // Behavioural aligner: one right shift of the smaller-exponent mantissa per en cycle,
    // OE registered one cycle after the last shift and left untouched by load.
    logic [MW-1:0] ma, mb;
    int            md;
    logic          shA, moe, hold_oe0;

    always @(posedge clk) begin
        if (!rst) begin
            ma <= '0; mb <= '0; md <= 0; shA <= 1'b0; moe <= 1'b0;
        end else if (norm_en) begin
            if (norm_load) begin
                ma  <= norm_A;
                mb  <= norm_B;
                shA <= (norm_eA < norm_eB);
                md  <= (norm_eA < norm_eB) ? int'(norm_eB - norm_eA) : int'(norm_eA - norm_eB);
            end else begin
                moe <= (md == 0);
                if (md != 0) begin
                    if (shA) ma <= ma >> 1;
                    else     mb <= mb >> 1;
                    md <= md - 1;
                end
            end
        end
    end

    assign norm_Am = ma;
    assign norm_Bm = mb;
    assign norm_OE = moe & ~hold_oe0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one operand pair; lat = edges after the accept edge until out_valid, -1 if never.
    task automatic do_op(input logic [MW-1:0] a, input logic [MW-1:0] b,
                         input logic [EW-1:0] ea, input logic [EW-1:0] eb, output int lat);
        in_A = a; in_B = b; in_eA = ea; in_eB = eb;
        in_valid = 1'b1;
        chk("accept_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (out_valid) begin
                lat = i - 1;
                break;
            end
            step();
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_out_valid", 64'(out_valid), 64'd0);
    endtask

    int            lat;
    logic [MW-1:0] held_b;

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; hold_oe0 = 1'b0;
        in_A = '0; in_B = '0; in_eA = '0; in_eB = '0;
        step(); step();

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_norm_en", 64'(norm_en), 64'd0);
        chk("rst_norm_load", 64'(norm_load), 64'd0);
        chk("rst_out_timeout", 64'(out_timeout), 64'd0);
        chk("rst_out_Am", 64'(out_Am), 64'd0);
        chk("rst_norm_A", 64'(norm_A), 64'd0);
`ifdef ALIGN_PERF_EN
        chk("rst_op_count", 64'(op_count), 64'd0);
`endif
        rst = 1'b1;
        step();

        // Equal exponents, stepped manually to see LOAD/SETTLE
        in_A = 53'h10000000000000; in_B = 53'h10000000000000;
        in_eA = 11'h3FF; in_eB = 11'h3FF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_load", 64'(norm_load), 64'd1);
        chk("t1_load_en", 64'(norm_en), 64'd1);
        chk("t1_load_in_ready", 64'(in_ready), 64'd0);
        chk("t1_norm_A", 64'(norm_A), 64'h10000000000000);
        step();
        chk("t1_settle_load", 64'(norm_load), 64'd0);
        chk("t1_settle_en", 64'(norm_en), 64'd1);
        step();
        chk("t1_run_not_valid", 64'(out_valid), 64'd0);
        step();
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_Am", 64'(out_Am), 64'h10000000000000);
        chk("t1_out_Bm", 64'(out_Bm), 64'h10000000000000);
        chk("t1_timeout", 64'(out_timeout), 64'd0);
        chk("t1_done_en", 64'(norm_en), 64'd0);
`ifdef ALIGN_PERF_EN
        chk("t1_last_cycles", 64'(last_cycles), 64'd1);
`endif
        release_out();

        // eA-eB=3: B shifted three places; four RUN cycles
        do_op(53'h1ABCDEF0123456, 53'h1FFFFFFFFFFFFF, 11'h402, 11'h3FF, lat);
        chk("t2_latency", 64'(lat), 64'd6);
        chk("t2_out_Am", 64'(out_Am), 64'h1ABCDEF0123456);
        chk("t2_out_Bm", 64'(out_Bm), 64'h03FFFFFFFFFFFF);
        chk("t2_timeout", 64'(out_timeout), 64'd0);
`ifdef ALIGN_PERF_EN
        chk("t2_last_cycles", 64'(last_cycles), 64'd4);
`endif
        release_out();

        // Back-to-back after OE=1: diff 5 on A must not finish on the stale flag
        do_op(53'h1000000000003F, 53'h15555555555555, 11'h3FA, 11'h3FF, lat);
        chk("t3_latency", 64'(lat), 64'd8);
        chk("t3_out_Am", 64'(out_Am), 64'h0000800000000001);
        chk("t3_out_Bm", 64'(out_Bm), 64'h15555555555555);
`ifdef ALIGN_PERF_EN
        chk("t3_last_cycles", 64'(last_cycles), 64'd6);
`endif
        // Backpressure in DONE for 10 cycles
        held_b = out_Bm;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_Bm", 64'(out_Bm), 64'(held_b));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_norm_en", 64'(norm_en), 64'd0);
        end
        release_out();

        // Aligner never raises OE: budget of 16 RUN cycles expires
        hold_oe0 = 1'b1;
        do_op(53'h12345678ABCDEF, 53'h10000000000000, 11'h3FF, 11'h3FF, lat);
        hold_oe0 = 1'b0;
        chk("tmo_latency", 64'(lat), 64'd18);
        chk("tmo_flag", 64'(out_timeout), 64'd1);
        chk("tmo_out_Am", 64'(out_Am), 64'h12345678ABCDEF);
`ifdef ALIGN_PERF_EN
        chk("tmo_last_cycles", 64'(last_cycles), 64'd16);
`endif
        release_out();

        // OE seen on the final budget cycle: completion beats timeout
        do_op(53'h10000000000001, 53'h1FFFFFFFFFFFFF, 11'h3FF, 11'h3F0, lat);
        chk("prio_latency", 64'(lat), 64'd18);
        chk("prio_timeout", 64'(out_timeout), 64'd0);
        chk("prio_out_Bm", 64'(out_Bm), 64'h3FFFFFFFFF);
`ifdef ALIGN_PERF_EN
        chk("prio_op_count", 64'(op_count), 64'd5);
`endif
        release_out();

        // Flush during RUN
        in_A = 53'h1F0F0F0F0F0F0F; in_B = 53'h10000000000000;
        in_eA = 11'h3FF; in_eB = 11'h3F5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("fl_in_run_en", 64'(norm_en), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_norm_en", 64'(norm_en), 64'd0);
        chk("fl_operand_kept", 64'(norm_A), 64'h1F0F0F0F0F0F0F);
`ifdef ALIGN_PERF_EN
        chk("fl_op_count", 64'(op_count), 64'd5);
        chk("fl_last_cycles", 64'(last_cycles), 64'd16);
`endif
        // Counter restarts from zero: a fresh equal-exponent op has minimum latency
        do_op(53'h11111111111111, 53'h12222222222222, 11'h100, 11'h100, lat);
        chk("postfl_latency", 64'(lat), 64'd3);
        chk("postfl_out_Bm", 64'(out_Bm), 64'h12222222222222);
        release_out();

        // Reset during LOAD
        in_A = 53'h1AAAAAAAAAAAAA; in_B = 53'h1BBBBBBBBBBBBB;
        in_eA = 11'h3FF; in_eB = 11'h3FE; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rl_load", 64'(norm_load), 64'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rl_in_ready", 64'(in_ready), 64'd1);
        chk("rl_out_valid", 64'(out_valid), 64'd0);
        chk("rl_norm_en", 64'(norm_en), 64'd0);
        chk("rl_norm_A", 64'(norm_A), 64'd0);
        chk("rl_out_Bm", 64'(out_Bm), 64'd0);
`ifdef ALIGN_PERF_EN
        chk("rl_op_count", 64'(op_count), 64'd0);
        chk("rl_last_cycles", 64'(last_cycles), 64'd0);
`endif
        do_op(53'h10000000000000, 53'h1FFFFFFFFFFFFF, 11'h3FF, 11'h3FE, lat);
        chk("postrst_latency", 64'(lat), 64'd4);
        chk("postrst_out_Bm", 64'(out_Bm), 64'h0FFFFFFFFFFFFF);
        release_out();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
